// File: rtl/normshift_seq_pkg.sv
// Shared types, default configuration and step-count helper for the
// sequential normalization shifter.
package cvw;

   typedef struct packed {
      int NORMSHIFTSZ;
      int LOGNORMSHIFTSZ;
   } cvw_t;

   localparam cvw_t CVW_DEFAULT = '{NORMSHIFTSZ: 64, LOGNORMSHIFTSZ: 8};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } normshiftstate_t;

   // Number of radix-2^stagew digits needed to cover a logsz-bit amount.
   function automatic int nstep(input int logsz, input int stagew);
      return (logsz + stagew - 1) / stagew;
   endfunction

endpackage

// File: rtl/normshift_seq_normshiftstage.sv
// One digit of the iterative left shift: shifts by digit * 2^(pos*STAGEW),
// with everything pushed past the MSB discarded.
module normshiftstage #(
   parameter int W      = 64,
   parameter int STAGEW = 4,
   parameter int CW     = 1
) (
   input  logic [W-1:0]      din,
   input  logic [STAGEW-1:0] digit,
   input  logic [CW-1:0]     pos,
   output logic [W-1:0]      dout
);

   logic [31:0] shamt;

   always_comb begin
      shamt = 32'(digit) << (32'(pos) * 32'(STAGEW));
      dout  = din << shamt;
   end

endmodule

// File: rtl/normshift_seq.sv
// Two-requester sequential normalization shifter, STAGEW amount bits per cycle.
// Optional feature: NORMSHIFT_ZEROBYPASS_EN sends zero-amount requests straight to DONE.
module normshift_seq
   import cvw::*;
#(
   parameter cvw_t P      = CVW_DEFAULT,
   parameter int   STAGEW = 4
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         FlushE,
   input  logic [1:0]                   ReqValid,
   output logic [1:0]                   ReqReady,
   input  logic [P.NORMSHIFTSZ-1:0]     ShiftIn0,
   input  logic [P.NORMSHIFTSZ-1:0]     ShiftIn1,
   input  logic [P.LOGNORMSHIFTSZ-1:0]  ShiftAmt0,
   input  logic [P.LOGNORMSHIFTSZ-1:0]  ShiftAmt1,
   output logic                         ShiftedValid,
   input  logic                         ShiftedReady,
   output logic [P.NORMSHIFTSZ-1:0]     Shifted,
   output logic                         ShiftedTag
);

   localparam int W     = P.NORMSHIFTSZ;
   localparam int LW    = P.LOGNORMSHIFTSZ;
   localparam int NSTEP = nstep(LW, STAGEW);
   localparam int AW    = NSTEP * STAGEW;
   localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

   normshiftstate_t   state_q, state_d;
   logic [CW-1:0]     step_q, step_d;
   logic              last_q, last_d;
   logic [W-1:0]      work_q, work_d;
   logic [AW-1:0]     amt_q, amt_d;
   logic              valid_q, valid_d;
   logic              tag_q, tag_d;

   logic [1:0]        gnt;
   logic              gnt_sel;
   logic [W-1:0]      sel_in;
   logic [AW-1:0]     sel_amt;
   logic [STAGEW-1:0] digit;
   logic [W-1:0]      stage_out;

   // Round-robin on ties; a grant is only possible in IDLE, outside reset and flush.
   always_comb begin
      gnt     = 2'b00;
      gnt_sel = (ReqValid == 2'b11) ? ~last_q : ReqValid[1];
      if (reset_n && !FlushE && state_q == IDLE && ReqValid != 2'b00)
         gnt = gnt_sel ? 2'b10 : 2'b01;
      sel_in  = gnt_sel ? ShiftIn1 : ShiftIn0;
      sel_amt = gnt_sel ? AW'(ShiftAmt1) : AW'(ShiftAmt0);
      digit   = amt_q[step_q*STAGEW +: STAGEW];
   end

   normshiftstage #(
      .W      (W),
      .STAGEW (STAGEW),
      .CW     (CW)
   ) u_stage (
      .din   (work_q),
      .digit (digit),
      .pos   (step_q),
      .dout  (stage_out)
   );

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      last_d  = last_q;
      work_d  = work_q;
      amt_d   = amt_q;
      valid_d = valid_q;
      tag_d   = tag_q;
      case (state_q)
         IDLE: begin
            if (gnt != 2'b00) begin
               work_d  = sel_in;
               amt_d   = sel_amt;
               tag_d   = gnt_sel;
               last_d  = gnt_sel;
               step_d  = '0;
               state_d = SHIFT;
`ifdef NORMSHIFT_ZEROBYPASS_EN
               if (sel_amt == '0) begin
                  state_d = DONE;
                  valid_d = 1'b1;
               end
`endif
            end
         end
         SHIFT: begin
            work_d = stage_out;
            step_d = step_q + CW'(1);
            if (step_q == CW'(NSTEP - 1)) begin
               step_d  = '0;
               state_d = DONE;
               valid_d = 1'b1;
            end
         end
         DONE: begin
            if (ShiftedReady) begin
               state_d = IDLE;
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
      if (FlushE) begin
         state_d = IDLE;
         step_d  = '0;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         step_q  <= '0;
         last_q  <= 1'b1;
         work_q  <= '0;
         amt_q   <= '0;
         valid_q <= 1'b0;
         tag_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         last_q  <= last_d;
         work_q  <= work_d;
         amt_q   <= amt_d;
         valid_q <= valid_d;
         tag_q   <= tag_d;
      end
   end

   assign ReqReady     = gnt;
   assign ShiftedValid = valid_q;
   assign Shifted      = work_q;
   assign ShiftedTag   = tag_q;

endmodule

// File: tb/tb_normshift_seq.sv
// Self-checking bench for normshift_seq (default config: 64-bit datapath,
// 8-bit amounts, STAGEW=4); honours NORMSHIFT_ZEROBYPASS_EN when defined.
module tb_normshift_seq;

   localparam int W     = 64;
   localparam int NSTEP = 2;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          FlushE = 1'b0;
   logic [1:0]    ReqValid = 2'b00;
   logic [1:0]    ReqReady;
   logic [W-1:0]  ShiftIn0 = '0;
   logic [W-1:0]  ShiftIn1 = '0;
   logic [7:0]    ShiftAmt0 = '0;
   logic [7:0]    ShiftAmt1 = '0;
   logic          ShiftedValid;
   logic          ShiftedReady = 1'b0;
   logic [W-1:0]  Shifted;
   logic          ShiftedTag;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [1:0]   vld;
      logic [W-1:0] in0;
      logic [7:0]   a0;
      logic [W-1:0] in1;
      logic [7:0]   a1;
      int           hold;
      logic         exp_tag;
      logic [W-1:0] exp_data;
   } vec_t;

   vec_t vecs[16];
   logic model_last;

   always #5 clk = ~clk;

   normshift_seq dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .FlushE       (FlushE),
      .ReqValid     (ReqValid),
      .ReqReady     (ReqReady),
      .ShiftIn0     (ShiftIn0),
      .ShiftIn1     (ShiftIn1),
      .ShiftAmt0    (ShiftAmt0),
      .ShiftAmt1    (ShiftAmt1),
      .ShiftedValid (ShiftedValid),
      .ShiftedReady (ShiftedReady),
      .Shifted      (Shifted),
      .ShiftedTag   (ShiftedTag)
   );

   function automatic logic [W-1:0] ref_shift(input logic [W-1:0] v, input logic [7:0] a);
      if (int'(a) >= W) return '0;
      return v << a;
   endfunction

   function automatic int exp_latency(input logic [7:0] amt);
      int zl;
`ifdef NORMSHIFT_ZEROBYPASS_EN
      zl = 1;
`else
      zl = NSTEP + 1;
`endif
      return (amt == 8'd0) ? zl : NSTEP + 1;
   endfunction

   function automatic vec_t mk(input logic [1:0] v, input logic [W-1:0] i0, input logic [7:0] x0,
                               input logic [W-1:0] i1, input logic [7:0] x1, input int h);
      vec_t r;
      r.vld = v; r.in0 = i0; r.a0 = x0; r.in1 = i1; r.a1 = x1; r.hold = h;
      r.exp_tag = 1'b0; r.exp_data = '0;
      return r;
   endfunction

   task automatic check_output(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic apply_stimulus(input string nm, input logic [1:0] vld,
                                 input logic [W-1:0] in0, input logic [7:0] a0,
                                 input logic [W-1:0] in1, input logic [7:0] a1,
                                 input logic exp_tag, input logic [W-1:0] exp_data, input int hold);
      int waited;
      int lat;
      logic [7:0] amt;
      amt = exp_tag ? a1 : a0;
      @(negedge clk);
      ReqValid = vld; ShiftIn0 = in0; ShiftAmt0 = a0; ShiftIn1 = in1; ShiftAmt1 = a1;
      #1;
      waited = 0;
      while (ReqReady == 2'b00 && waited < 10) begin
         @(negedge clk); #1; waited++;
      end
      check_output({nm, "_grant"}, 64'(ReqReady), exp_tag ? 64'd2 : 64'd1);
      @(negedge clk);
      ReqValid = 2'b00; ShiftIn0 = ~in0; ShiftAmt0 = ~a0; ShiftIn1 = ~in1; ShiftAmt1 = ~a1;
      lat = 1;
      while (!ShiftedValid && lat < 20) begin
         @(negedge clk); lat++;
      end
      check_output({nm, "_latency"}, 64'(lat), 64'(exp_latency(amt)));
      check_output({nm, "_data"}, Shifted, exp_data);
      check_output({nm, "_tag"}, 64'(ShiftedTag), 64'(exp_tag));
      ReqValid = 2'b11;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk); #1;
         check_output({nm, "_hold_data"}, Shifted, exp_data);
         check_output({nm, "_hold_tag"}, 64'(ShiftedTag), 64'(exp_tag));
         check_output({nm, "_hold_valid"}, 64'(ShiftedValid), 64'd1);
         check_output({nm, "_hold_ready"}, 64'(ReqReady), 64'd0);
      end
      ReqValid = 2'b00;
      ShiftedReady = 1'b1;
      @(negedge clk);
      ShiftedReady = 1'b0;
      check_output({nm, "_drop_valid"}, 64'(ShiftedValid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL timeout actual=running required=finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      vecs[0] = mk(2'b11, 64'h1, 8'h25, 64'hDEAD_BEEF, 8'h03, 5);
      vecs[1] = mk(2'b11, 64'h1234, 8'h04, 64'h00F0_0000_0000_00AB, 8'h10, 0);
      vecs[2] = mk(2'b10, 64'h0, 8'h00, 64'hCAFE_F00D_1234_5678, 8'h00, 1);
      vecs[3] = mk(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 8'd64, 64'h0, 8'h00, 0);
      vecs[4] = mk(2'b01, 64'h1, 8'hFF, 64'h0, 8'h00, 0);
      vecs[5] = mk(2'b01, 64'h3, 8'd63, 64'h0, 8'h00, 2);
      vecs[6] = mk(2'b10, 64'h0, 8'h00, 64'h1, 8'h0F, 0);
      vecs[7] = mk(2'b01, 64'h5, 8'hF0, 64'h0, 8'h00, 0);
      for (int i = 8; i < 16; i++)
         vecs[i] = mk(2'($urandom_range(1, 3)), {$urandom, $urandom}, 8'($urandom_range(0, 80)),
                      {$urandom, $urandom}, 8'($urandom_range(0, 80)), int'($urandom_range(0, 2)));

      // Expected grants follow the round-robin rule: ties alternate, FMA wins the first one.
      model_last = 1'b1;
      for (int i = 0; i < 16; i++) begin
         vecs[i].exp_tag  = (vecs[i].vld == 2'b11) ? ~model_last : vecs[i].vld[1];
         model_last       = vecs[i].exp_tag;
         vecs[i].exp_data = vecs[i].exp_tag ? ref_shift(vecs[i].in1, vecs[i].a1)
                                            : ref_shift(vecs[i].in0, vecs[i].a0);
      end

      ReqValid = 2'b11;
      ShiftIn0 = 64'hFFFF; ShiftIn1 = 64'hFFFF;
      #12;
      check_output("rst_ready", 64'(ReqReady), 64'd0);
      check_output("rst_valid", 64'(ShiftedValid), 64'd0);
      check_output("rst_shifted", Shifted, 64'd0);
      check_output("rst_tag", 64'(ShiftedTag), 64'd0);
      @(negedge clk);
      ReqValid = 2'b00;
      reset_n = 1'b1;

      for (int i = 0; i < 16; i++)
         apply_stimulus($sformatf("vec%0d", i), vecs[i].vld, vecs[i].in0, vecs[i].a0,
                        vecs[i].in1, vecs[i].a1, vecs[i].exp_tag, vecs[i].exp_data, vecs[i].hold);

      // Flush one cycle after the grant: the result must never appear.
      @(negedge clk);
      ReqValid = 2'b01; ShiftIn0 = 64'h3; ShiftAmt0 = 8'd5;
      #1;
      check_output("flush_grant", 64'(ReqReady), 64'd1);
      @(negedge clk);
      ReqValid = 2'b00; FlushE = 1'b1;
      @(negedge clk);
      FlushE = 1'b0;
      check_output("flush_valid", 64'(ShiftedValid), 64'd0);
      ReqValid = 2'b01;
      #1;
      check_output("flush_idle_ready", 64'(ReqReady), 64'd1);
      ReqValid = 2'b00;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_output("flush_no_valid", 64'(ShiftedValid), 64'd0);
      end
      apply_stimulus("post_flush", 2'b01, 64'h7, 8'd2, 64'h0, 8'd0, 1'b0, 64'h1C, 0);

      // Reset while shifting: outputs clear at once and the tie pointer returns to FMA.
      @(negedge clk);
      ReqValid = 2'b10; ShiftIn1 = 64'h55; ShiftAmt1 = 8'h11;
      #1;
      check_output("rstmid_grant", 64'(ReqReady), 64'd2);
      @(negedge clk);
      ReqValid = 2'b11; reset_n = 1'b0;
      #1;
      check_output("rstmid_shifted", Shifted, 64'd0);
      check_output("rstmid_valid", 64'(ShiftedValid), 64'd0);
      check_output("rstmid_tag", 64'(ShiftedTag), 64'd0);
      check_output("rstmid_ready", 64'(ReqReady), 64'd0);
      @(negedge clk);
      check_output("rstmid_ready_held", 64'(ReqReady), 64'd0);
      reset_n = 1'b1;
      #1;
      check_output("rstmid_first_tie", 64'(ReqReady), 64'd1);
      ReqValid = 2'b00;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_output("rstmid_no_valid", 64'(ShiftedValid), 64'd0);
      end
      apply_stimulus("post_reset", 2'b11, 64'h1, 8'd1, 64'h2, 8'd2, 1'b0, 64'h2, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/normshift_seq.md
NORMSHIFT_SEQ -- requirements
Module: normshift_seq

Interface
REQ-001 Parameter P, default cvw::cvw_t config, supplies NORMSHIFTSZ (datapath width) and LOGNORMSHIFTSZ (shift-amount width).
REQ-002 Parameter STAGEW, default 4, is the shift-amount bits consumed per SHIFT cycle.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 FlushE  input  1  synchronous cancel of any in-flight operation.
REQ-006 ReqValid  input  2  request valid per requester (bit0 FMA, bit1 DivSqrt/Cvt).
REQ-007 ReqReady  output  2  request accepted when ReqValid[i]&ReqReady[i].
REQ-008 ShiftIn0, ShiftIn1  input  NORMSHIFTSZ each  operand per requester.
REQ-009 ShiftAmt0, ShiftAmt1  input  LOGNORMSHIFTSZ each  left-shift amount per requester.
REQ-010 ShiftedValid  output  1  result valid.
REQ-011 ShiftedReady  input  1  consumer accepts result.
REQ-012 Shifted  output  NORMSHIFTSZ  result = operand << amount, truncated to NORMSHIFTSZ.
REQ-013 ShiftedTag  output  1  index of requester owning the result.

Function
REQ-014 NSTEP = ceil(LOGNORMSHIFTSZ/STAGEW); amount is split into NSTEP radix-2^STAGEW digits, zero-extended at top.
REQ-015 States IDLE, SHIFT, DONE; ReqReady nonzero only in IDLE, at most one bit set.
REQ-016 Arbitration round-robin: single requester granted directly; both valid -> grant opposite of LastGrant; LastGrant resets to 1 (FMA wins first tie).
REQ-017 IDLE + grant at cycle t: latch operand, amount, tag; go to SHIFT with StepCnt=0.
REQ-018 SHIFT: each cycle working register <<= (digit[StepCnt] << (StepCnt*STAGEW)), StepCnt increments; after digit NSTEP-1 go to DONE.
REQ-019 Fixed latency: ShiftedValid rises at cycle t+NSTEP+1; Shifted, ShiftedTag held stable while ShiftedValid & !ShiftedReady.
REQ-020 DONE & ShiftedReady -> IDLE next cycle; no new grant in DONE cycle (minimum issue interval NSTEP+2).
REQ-021 Bits shifted past MSB are discarded; amount >= NORMSHIFTSZ yields zero result, no error.
REQ-022 FlushE in any state: next state IDLE, ShiftedValid low next cycle, result discarded; FlushE in IDLE blocks that cycle's grant.
REQ-023 Requester inputs are sampled only at grant; changes afterward have no effect.

Reset
REQ-024 reset_n low: state IDLE, StepCnt 0, LastGrant 1, working register 0, ShiftedValid 0, ShiftedTag 0, Shifted 0, ReqReady 0 while asserted.
REQ-025 reset_n deasserted mid-operation behaves as REQ-024; no partial result emerges.

Configuration
REQ-026 Macro NORMSHIFT_ZEROBYPASS_EN defined: granted amount 0 goes IDLE -> DONE directly, ShiftedValid at t+1.
REQ-027 Macro undefined: amount 0 takes full NSTEP SHIFT cycles like any other amount.

Structure
REQ-028 cvw package holds enum normshiftstate_t {IDLE, SHIFT, DONE} and NSTEP derivation function.
REQ-029 One sub-module normshiftstage: combinational left shift by one STAGEW-bit digit at a given digit position; instantiated once, reused every SHIFT cycle.

Verification (STAGEW=4, LOGNORMSHIFTSZ=8, NSTEP=2)
REQ-030 FMA req ShiftIn0=1, ShiftAmt0=0x25 at t -> Shifted=1<<37, ShiftedTag=0, ShiftedValid at t+3.
REQ-031 Both valid at first IDLE -> FMA granted; both valid again -> DivSqrt granted; tags 0 then 1.
REQ-032 ShiftedReady held low 5 cycles -> Shifted, ShiftedTag stable, ReqReady=0 throughout.
REQ-033 FlushE at t+1 of an op -> no ShiftedValid; IDLE at t+2, new request accepted.
REQ-034 Amount 0: with macro ShiftedValid at t+1, without at t+3; Shifted=ShiftIn. Amount >= NORMSHIFTSZ -> Shifted=0.
REQ-035 reset_n low during SHIFT -> all outputs 0 immediately; first grant after release goes to FMA on tie.
